// File: rtl/ysyx_23060025_trap_ctrl.sv
// Trap sequencer and CSR-port arbiter between the WBU and the machine-mode CSR file.
// Optional trap counter enabled by defining YSYX_23060025_TRAP_CNT_EN.
module ysyx_23060025_trap_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  trap_valid_i,
    output logic                  trap_ready_o,
    input  logic [1:0]            trap_type_i,
    input  logic [DATA_WIDTH-1:0] trap_pc_i,
    input  logic                  wbu_csr_we_i,
    input  logic [11:0]           wbu_csr_waddr_i,
    input  logic [DATA_WIDTH-1:0] wbu_csr_wdata_i,
    input  logic [11:0]           wbu_csr_raddr_i,
    output logic [DATA_WIDTH-1:0] wbu_csr_rdata_o,
    output logic                  wbu_csr_ready_o,
    output logic                  csr_we_o,
    output logic [11:0]           csr_waddr_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic [11:0]           csr_raddr_o,
    input  logic [DATA_WIDTH-1:0] csr_rdata_i,
    output logic                  redirect_valid_o,
    input  logic                  redirect_ready_i,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    output logic [31:0]           trap_cnt_o
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [1:0] TRAP_ECALL = 2'b01;
    localparam logic [1:0] TRAP_MRET  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_CAUSE,
        SAVE_STATUS,
        RESTORE_STATUS,
        LOAD_TGT,
        REDIRECT
    } state_t;

    state_t                state, state_next;
    logic [1:0]            trap_type_q;
    logic [DATA_WIDTH-1:0] trap_pc_q;
    logic [DATA_WIDTH-1:0] redirect_pc_q;
    logic [DATA_WIDTH-1:0] status_ecall;
    logic [DATA_WIDTH-1:0] status_mret;
    logic                  trap_accept;
    logic                  redirect_done;
    logic                  is_ecall;

    assign trap_accept   = trap_valid_i && (state == IDLE);
    assign redirect_done = (state == REDIRECT) && redirect_ready_i;
    assign is_ecall      = (trap_type_q == TRAP_ECALL);

    assign trap_ready_o     = (state == IDLE);
    assign wbu_csr_ready_o  = (state == IDLE);
    assign wbu_csr_rdata_o  = csr_rdata_i;
    assign redirect_valid_o = (state == REDIRECT);
    assign redirect_pc_o    = redirect_pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            trap_type_q   <= '0;
            trap_pc_q     <= '0;
            redirect_pc_q <= '0;
        end else begin
            state <= state_next;
            if (trap_accept) begin
                trap_type_q <= trap_type_i;
                trap_pc_q   <= trap_pc_i;
            end
            if (state == LOAD_TGT) begin
                redirect_pc_q <= {csr_rdata_i[DATA_WIDTH-1:2], 2'b00};
            end
        end
    end

    // mstatus images for trap entry and return, built from the live read data
    always_comb begin
        status_ecall     = csr_rdata_i;
        status_ecall[7]  = csr_rdata_i[3];
        status_ecall[3]  = 1'b0;
        status_ecall[12:11] = 2'b11;
        status_mret      = csr_rdata_i;
        status_mret[3]   = csr_rdata_i[7];
        status_mret[7]   = 1'b1;
        status_mret[12:11] = 2'b11;
    end

    always_comb begin
        state_next  = state;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        csr_raddr_o = wbu_csr_raddr_i;
        case (state)
            IDLE: begin
                csr_we_o    = wbu_csr_we_i;
                csr_waddr_o = wbu_csr_waddr_i;
                csr_wdata_o = wbu_csr_wdata_i;
                if (trap_accept) begin
                    if (trap_type_i == TRAP_ECALL) begin
                        state_next = SAVE_EPC;
                    end else if (trap_type_i == TRAP_MRET) begin
                        state_next = RESTORE_STATUS;
                    end
                end
            end
            SAVE_EPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = {trap_pc_q[DATA_WIDTH-1:2], 2'b00};
                state_next  = SAVE_CAUSE;
            end
            SAVE_CAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = DATA_WIDTH'(11);
                state_next  = SAVE_STATUS;
            end
            SAVE_STATUS: begin
                csr_raddr_o = CSR_MSTATUS;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = status_ecall;
                state_next  = LOAD_TGT;
            end
            RESTORE_STATUS: begin
                csr_raddr_o = CSR_MSTATUS;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = status_mret;
                state_next  = LOAD_TGT;
            end
            LOAD_TGT: begin
                csr_raddr_o = is_ecall ? CSR_MTVEC : CSR_MEPC;
                state_next  = REDIRECT;
            end
            REDIRECT: begin
                if (redirect_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef YSYX_23060025_TRAP_CNT_EN
    logic [31:0] trap_cnt_q;

    // Saturating count of completed redirect handshakes
    always_ff @(posedge clock) begin
        if (reset) begin
            trap_cnt_q <= '0;
        end else if (redirect_done && (trap_cnt_q != 32'hFFFF_FFFF)) begin
            trap_cnt_q <= trap_cnt_q + 32'd1;
        end
    end

    assign trap_cnt_o = trap_cnt_q;
`else
    assign trap_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060025_trap_ctrl.sv
// Scoreboard bench for ysyx_23060025_trap_ctrl with a behavioural CSR file model.
module tb_ysyx_23060025_trap_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        trap_valid_i;
    logic        trap_ready_o;
    logic [1:0]  trap_type_i;
    logic [31:0] trap_pc_i;
    logic        wbu_csr_we_i;
    logic [11:0] wbu_csr_waddr_i;
    logic [31:0] wbu_csr_wdata_i;
    logic [11:0] wbu_csr_raddr_i;
    logic [31:0] wbu_csr_rdata_o;
    logic        wbu_csr_ready_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic [11:0] csr_raddr_o;
    logic [31:0] csr_rdata_i;
    logic        redirect_valid_o;
    logic        redirect_ready_i;
    logic [31:0] redirect_pc_o;
    logic [31:0] trap_cnt_o;

    always #5 clock = ~clock;

    ysyx_23060025_trap_ctrl #(.DATA_WIDTH(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .trap_valid_i     (trap_valid_i),
        .trap_ready_o     (trap_ready_o),
        .trap_type_i      (trap_type_i),
        .trap_pc_i        (trap_pc_i),
        .wbu_csr_we_i     (wbu_csr_we_i),
        .wbu_csr_waddr_i  (wbu_csr_waddr_i),
        .wbu_csr_wdata_i  (wbu_csr_wdata_i),
        .wbu_csr_raddr_i  (wbu_csr_raddr_i),
        .wbu_csr_rdata_o  (wbu_csr_rdata_o),
        .wbu_csr_ready_o  (wbu_csr_ready_o),
        .csr_we_o         (csr_we_o),
        .csr_waddr_o      (csr_waddr_o),
        .csr_wdata_o      (csr_wdata_o),
        .csr_raddr_o      (csr_raddr_o),
        .csr_rdata_i      (csr_rdata_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_ready_i (redirect_ready_i),
        .redirect_pc_o    (redirect_pc_o),
        .trap_cnt_o       (trap_cnt_o)
    );

    // CSR file model: combinational read, write on the clock, plus a bench backdoor
    logic [31:0] csr_mem [0:4095];
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clock) begin
        if (csr_we_o) csr_mem[csr_waddr_o] <= csr_wdata_o;
        else if (bd_we) csr_mem[bd_addr] <= bd_data;
    end
    assign csr_rdata_i = csr_mem[csr_raddr_o];

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_redir[$];
    wr_t         mon_wr;
    logic [31:0] mon_pc;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_cnt = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every CSR write and every redirect handshake is matched in order
    always @(negedge clock) begin
        if (!reset) begin
            if (csr_we_o) begin
                if (exp_wr.size() == 0) begin
                    checkOutput("unexpected_write", {20'd0, csr_waddr_o}, 32'hFFFF_FFFF);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    checkOutput("wr_addr", {20'd0, csr_waddr_o}, {20'd0, mon_wr.addr});
                    checkOutput("wr_data", csr_wdata_o, mon_wr.data);
                end
            end
            if (redirect_valid_o && redirect_ready_i) begin
                if (exp_redir.size() == 0) begin
                    checkOutput("unexpected_redirect", redirect_pc_o, 32'hFFFF_FFFF);
                end else begin
                    mon_pc = exp_redir.pop_front();
                    checkOutput("redirect_pc", redirect_pc_o, mon_pc);
                end
            end
        end
    end

    task automatic bdWrite(input logic [11:0] addr, input logic [31:0] data);
        bd_we = 1'b1; bd_addr = addr; bd_data = data;
        @(posedge clock); #1;
        bd_we = 1'b0;
    endtask

    function automatic wr_t mkWr(input logic [11:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        return w;
    endfunction

    // Called #1 after a posedge with the DUT idle; runs one ECALL/MRET to completion
    task automatic applyStimulus(input logic [1:0] ttype, input logic [31:0] pc,
                                 input logic [31:0] exp_tgt, input int ready_delay,
                                 input bit wbu_same, input bit wbu_during);
        logic [31:0] s;
        int nwr, lat, cyc;
        bit seen;
        s = csr_mem[12'h300];
        nwr = (ttype == 2'b01) ? 3 : 1;
        lat = (ttype == 2'b01) ? 5 : 3;
        redirect_ready_i = (ready_delay == 0);
        trap_valid_i = 1'b1; trap_type_i = ttype; trap_pc_i = pc;
        if (wbu_same) begin
            wbu_csr_we_i = 1'b1; wbu_csr_waddr_i = 12'h305; wbu_csr_wdata_i = exp_tgt;
            exp_wr.push_back(mkWr(12'h305, exp_tgt));
        end
        if (ttype == 2'b01) begin
            exp_wr.push_back(mkWr(12'h341, pc & 32'hFFFF_FFFC));
            exp_wr.push_back(mkWr(12'h342, 32'd11));
            exp_wr.push_back(mkWr(12'h300, (s & ~32'h1888) | 32'h1800 | ((s & 32'h8) << 4)));
        end else begin
            exp_wr.push_back(mkWr(12'h300, (s & ~32'h1888) | 32'h1880 | ((s >> 4) & 32'h8)));
        end
        exp_redir.push_back(exp_tgt);
        if (wbu_during) exp_wr.push_back(mkWr(12'h340, 32'h1234_5678));
        @(negedge clock);
        checkOutput("trap_ready_c0", trap_ready_o, 1);
        @(posedge clock); #1;
        trap_valid_i = 1'b0; trap_type_i = 2'b00;
        wbu_csr_we_i = wbu_during; wbu_csr_waddr_i = 12'h340; wbu_csr_wdata_i = 32'h1234_5678;
        seen = 0;
        cyc = 1;
        while (cyc <= 12) begin
            @(negedge clock);
            if (redirect_valid_o) begin
                seen = 1;
                break;
            end
            checkOutput("csr_we_seq", csr_we_o, (cyc <= nwr));
            if (wbu_during) checkOutput("wbu_blocked", wbu_csr_ready_o, 0);
            @(posedge clock); #1;
            cyc++;
        end
        if (!seen) begin
            checkOutput("redirect_timeout", 0, 1);
        end else begin
            checkOutput("redirect_latency", cyc, lat);
            checkOutput("csr_we_redirect", csr_we_o, 0);
            if (wbu_during) checkOutput("wbu_blocked_redir", wbu_csr_ready_o, 0);
            for (int d = 0; d < ready_delay; d++) begin
                checkOutput("valid_hold", redirect_valid_o, 1);
                checkOutput("pc_hold", redirect_pc_o, exp_tgt);
                @(posedge clock); #1;
                if (d == ready_delay - 1) redirect_ready_i = 1'b1;
                @(negedge clock);
            end
            checkOutput("valid_final", redirect_valid_o, 1);
        end
        @(posedge clock); #1;
        redirect_ready_i = 1'b0;
`ifdef YSYX_23060025_TRAP_CNT_EN
        if (seen) exp_cnt = exp_cnt + 1;
`endif
        @(negedge clock);
        checkOutput("idle_after", trap_ready_o, 1);
        checkOutput("redirect_low", redirect_valid_o, 0);
        checkOutput("trap_cnt", trap_cnt_o, exp_cnt);
        if (wbu_during) begin
            checkOutput("wbu_ready_idle", wbu_csr_ready_o, 1);
            checkOutput("wbu_commit", csr_we_o, 1);
        end
        @(posedge clock); #1;
        wbu_csr_we_i = 1'b0;
    endtask

    task automatic applyNoop(input logic [1:0] ttype);
        trap_valid_i = 1'b1; trap_type_i = ttype; trap_pc_i = 32'h8000_0abc;
        @(negedge clock);
        checkOutput("noop_ready", trap_ready_o, 1);
        @(posedge clock); #1;
        trap_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("noop_idle", trap_ready_o, 1);
            checkOutput("noop_no_redirect", redirect_valid_o, 0);
            checkOutput("noop_cnt", trap_cnt_o, exp_cnt);
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        trap_valid_i = 1'b0; trap_type_i = 2'b00; trap_pc_i = '0;
        wbu_csr_we_i = 1'b0; wbu_csr_waddr_i = '0; wbu_csr_wdata_i = '0; wbu_csr_raddr_i = '0;
        redirect_ready_i = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_trap_ready", trap_ready_o, 1);
        checkOutput("rst_wbu_ready", wbu_csr_ready_o, 1);
        checkOutput("rst_redirect_valid", redirect_valid_o, 0);
        checkOutput("rst_redirect_pc", redirect_pc_o, 0);
        checkOutput("rst_trap_cnt", trap_cnt_o, 0);
        @(posedge clock); #1;

        bdWrite(12'h300, 32'h0000_1808);
        bdWrite(12'h305, 32'h8000_0100);

        // Idle pass-through of the WBU read and write ports
        wbu_csr_we_i = 1'b1; wbu_csr_waddr_i = 12'h340; wbu_csr_wdata_i = 32'hA5A5_0001;
        wbu_csr_raddr_i = 12'h305;
        exp_wr.push_back(mkWr(12'h340, 32'hA5A5_0001));
        @(negedge clock);
        checkOutput("idle_raddr", {20'd0, csr_raddr_o}, 32'h305);
        checkOutput("idle_rdata", wbu_csr_rdata_o, 32'h8000_0100);
        @(posedge clock); #1;
        wbu_csr_we_i = 1'b0;

        applyStimulus(2'b01, 32'h8000_0012, 32'h8000_0100, 0, 0, 0);
        checkOutput("mepc_saved", csr_mem[12'h341], 32'h8000_0010);
        checkOutput("mcause_saved", csr_mem[12'h342], 32'h0000_000B);
        checkOutput("mstatus_ecall", csr_mem[12'h300], 32'h0000_1880);

        bdWrite(12'h341, 32'h8000_0014);
        applyStimulus(2'b10, 32'h0, 32'h8000_0014, 0, 0, 0);
        checkOutput("mstatus_mret", csr_mem[12'h300], 32'h0000_1888);

        applyStimulus(2'b01, 32'h8000_0030, 32'h8000_0100, 0, 0, 1);
        applyStimulus(2'b01, 32'h8000_0040, 32'h8000_0200, 0, 1, 0);
        applyStimulus(2'b01, 32'h8000_0050, 32'h8000_0200, 4, 0, 0);

        applyNoop(2'b00);
        applyNoop(2'b11);

        // Reset while the sequence is in SAVE_CAUSE
        bdWrite(12'h300, 32'h0000_1808);
        trap_valid_i = 1'b1; trap_type_i = 2'b01; trap_pc_i = 32'h8000_0060;
        exp_wr.push_back(mkWr(12'h341, 32'h8000_0060));
        @(posedge clock); #1;
        trap_valid_i = 1'b0; trap_type_i = 2'b00;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_cnt = '0;
        @(negedge clock);
        checkOutput("rst_mid_idle", trap_ready_o, 1);
        checkOutput("rst_mid_redirect", redirect_valid_o, 0);
        checkOutput("rst_mid_mstatus", csr_mem[12'h300], 32'h0000_1808);
        checkOutput("rst_mid_cnt", trap_cnt_o, 0);
        @(posedge clock); #1;

        applyStimulus(2'b01, 32'h8000_0070, 32'h8000_0200, 0, 0, 0);
        applyStimulus(2'b01, 32'h8000_0080, 32'h8000_0200, 1, 0, 0);
`ifdef YSYX_23060025_TRAP_CNT_EN
        checkOutput("cnt_two", trap_cnt_o, 32'd2);
`endif

        repeat (2) @(negedge clock);
        checkOutput("wr_queue_empty", exp_wr.size(), 0);
        checkOutput("redir_queue_empty", exp_redir.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060025_trap_ctrl.md
Name: ysyx_23060025_trap_ctrl

Overview:
- Trap sequencer and CSR-port arbiter between the WBU and the machine-mode CSR file.
- On an accepted ECALL it writes mepc, mcause and mstatus over several cycles, then redirects the PC to mtvec.
- On MRET it restores mstatus, then redirects the PC to mepc.
- While a sequence is running it owns the single CSR read/write port and stalls WBU CSR accesses.

Parameters:
- DATA_WIDTH, 32, CSR and PC width.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- trap_valid_i  in  1  trap request from the WBU.
- trap_ready_o  out  1  controller can accept a trap; high only in IDLE.
- trap_type_i  in  2  01=ECALL, 10=MRET; 00 and 11 are no-op.
- trap_pc_i  in  DATA_WIDTH  PC of the trapping instruction.
- wbu_csr_we_i  in  1  WBU CSR write request (csrrw/csrrs/csrrc).
- wbu_csr_waddr_i  in  12  WBU CSR write address.
- wbu_csr_wdata_i  in  DATA_WIDTH  WBU CSR write data.
- wbu_csr_raddr_i  in  12  WBU CSR read address.
- wbu_csr_rdata_o  out  DATA_WIDTH  equals csr_rdata_i.
- wbu_csr_ready_o  out  1  WBU owns the CSR port; high only in IDLE.
- csr_we_o  out  1  CSR file write enable.
- csr_waddr_o  out  12  CSR file write address.
- csr_wdata_o  out  DATA_WIDTH  CSR file write data.
- csr_raddr_o  out  12  CSR file read address.
- csr_rdata_i  in  DATA_WIDTH  CSR file read data, combinational.
- redirect_valid_o  out  1  PC redirect request to the IFU.
- redirect_ready_i  in  1  IFU accepts the redirect.
- redirect_pc_o  out  DATA_WIDTH  redirect target.
- trap_cnt_o  out  32  number of completed traps (see Optional Feature).

Behaviour:
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
- mstatus fields: MIE bit 3, MPIE bit 7, MPP bits 12:11.
- Trap accept: trap_valid_i && trap_ready_o. On accept, latch trap_type_i and trap_pc_i.

States (CSR port behaviour in each):
- IDLE:
  - csr_we_o = wbu_csr_we_i, csr_waddr_o/csr_wdata_o pass through from the WBU.
  - csr_raddr_o = wbu_csr_raddr_i.
  - On accept: ECALL -> SAVE_EPC; MRET -> RESTORE_STATUS; no-op -> stay IDLE, trap consumed, no redirect, counter unchanged.
- SAVE_EPC: write mepc = latched PC with bits[1:0] forced 0 -> SAVE_CAUSE.
- SAVE_CAUSE: write mcause = 32'd11 -> SAVE_STATUS.
- SAVE_STATUS: csr_raddr_o = 0x300; write mstatus = rdata with MPIE = old MIE, MIE = 0, MPP = 2'b11 -> LOAD_TGT.
- RESTORE_STATUS: csr_raddr_o = 0x300; write mstatus = rdata with MIE = old MPIE, MPIE = 1, MPP = 2'b11 -> LOAD_TGT.
- LOAD_TGT: csr_raddr_o = 0x305 (ECALL) or 0x341 (MRET); register redirect_pc_o = {rdata[31:2], 2'b00}; no write -> REDIRECT.
- REDIRECT:
  - redirect_valid_o = 1; redirect_pc_o held stable.
  - On redirect_ready_i -> IDLE and trap counter increments.
  - A ready already high on the first REDIRECT cycle completes in that cycle.

Latency (accept in cycle 0):
- ECALL: writes in cycles 1-3, target captured in cycle 4, redirect_valid_o first high in cycle 5.
- MRET: write in cycle 1, capture in cycle 2, redirect_valid_o in cycle 3.

Port ownership and simultaneous events:
- Outside IDLE, all WBU CSR writes are blocked and wbu_csr_ready_o = 0. The WBU holds its request until ready.
- A WBU write and a trap accept in the same IDLE cycle: the WBU write commits that cycle, and the sequence starts next cycle. A WBU write to mtvec or mepc in that cycle is therefore visible to LOAD_TGT.
- csr_we_o is low in LOAD_TGT and REDIRECT, and in IDLE when there is no WBU write.

Reset:
- State goes to IDLE.
- redirect_valid_o = 0, redirect_pc_o = 0, trap_cnt_o = 0, latched type/PC = 0.
- Reset mid-sequence abandons the trap; CSR writes already committed are not undone.

Optional Feature:
- Macro: YSYX_23060025_TRAP_CNT_EN.
- Defined: trap_cnt_o is a 32-bit register. It is cleared by reset and increments by 1 on each REDIRECT handshake. It saturates at 32'hFFFFFFFF.
- Undefined: the counter register is absent and trap_cnt_o is tied to 0. All other behaviour is identical.

Test Plan:
- ECALL at pc 0x80000012, mstatus 0x1808, mtvec 0x80000100, redirect_ready_i=1 -> mepc=0x80000010, mcause=0xB, mstatus=0x1880 in cycles 1-3; redirect_pc_o=0x80000100 in cycle 5; trap_ready_o high in cycle 6.
- MRET with mstatus 0x1880, mepc 0x80000014 -> mstatus=0x1888 in cycle 1; redirect_pc_o=0x80000014 in cycle 3.
- During ECALL, WBU writes mscratch-style 0x340 from cycle 1 -> wbu_csr_ready_o=0 and no WBU write through cycle 5; the write commits in the first IDLE cycle.
- Same-cycle WBU write mtvec=0x80000200 and ECALL accept -> redirect_pc_o=0x80000200.
- redirect_ready_i held low for 4 cycles -> redirect_valid_o high with redirect_pc_o stable for those cycles; completes on the 5th cycle.
- Reset asserted in SAVE_CAUSE -> next cycle IDLE, redirect_valid_o=0, mstatus unchanged by the trap; with the macro defined, trap_cnt_o=0 and equals 2 after two further ECALLs.
